// File: rtl/snake_key_dir_ctrl.sv
// snake_key_dir_ctrl
// Input conditioner between the board pushbuttons and the snake game FSM.
// Each button is synchronised, debounced and edge-detected. The first four
// buttons are direction keys (0 RIGHT, 1 UP, 2 LEFT, 3 DOWN). Turn requests
// are filtered against the last pending direction and buffered in a small
// FIFO, which releases one turn per game step.
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   Resetn       in   asynchronous active-low reset
//   KEY          in   raw asynchronous buttons [N_KEYS]
//   step         in   one-cycle pulse per snake move
//   key_level    out  debounced pressed state (1 = pressed)
//   key_press    out  one-cycle pulse on each debounced press edge
//   dir          out  current direction
//   dir_changed  out  one-cycle pulse when dir updates
//   q_count      out  number of queued turns
//   turn_dropped out  one-cycle pulse when a valid turn is lost to a full FIFO
module snake_key_dir_ctrl #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int QDEPTH          = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          Resetn,
  input  logic [N_KEYS-1:0]             KEY,
  input  logic                          step,
  output logic [N_KEYS-1:0]             key_level,
  output logic [N_KEYS-1:0]             key_press,
  output logic [1:0]                    dir,
  output logic                          dir_changed,
  output logic [$clog2(QDEPTH+1)-1:0]   q_count,
  output logic                          turn_dropped
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int QC_W  = $clog2(QDEPTH + 1);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  // Raw level of a released button; XOR with it normalises to 1 = pressed.
  localparam logic [N_KEYS-1:0] RAW_RELEASED = {N_KEYS{KEY_ACTIVE_LOW}};
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST     = PTR_W'(QDEPTH - 1);
  localparam logic [QC_W-1:0]   QC_FULL      = QC_W'(QDEPTH);

  // Circular pointer advance, wrapping at QDEPTH.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) return '0;
    return p + PTR_W'(1);
  endfunction

  // Lowest-index press wins; result is {valid, direction}.
  function automatic logic [2:0] pick_turn(input logic [3:0] p);
    if (p[0]) return 3'b100;
    if (p[1]) return 3'b101;
    if (p[2]) return 3'b110;
    if (p[3]) return 3'b111;
    return 3'b000;
  endfunction

  logic [N_KEYS-1:0] key_sync_p0;
  logic [N_KEYS-1:0] key_sync_p1;
  logic [N_KEYS-1:0] key_pressed_p1;
  logic [CNT_W-1:0]  db_cnt [N_KEYS];
  logic [N_KEYS-1:0] key_level_d;

  logic [1:0]        fifo_mem [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  tail_idx;

  logic [2:0]        cand;
  logic [1:0]        ref_dir;
  logic              turn_ok;
  logic              q_full;
  logic              do_pop;
  logic              do_push;
  logic              do_drop;

  // ---- stage p0/p1: two-flop synchroniser on the raw buttons
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      key_sync_p0 <= RAW_RELEASED;
      key_sync_p1 <= RAW_RELEASED;
    end else begin
      key_sync_p0 <= KEY;
      key_sync_p1 <= key_sync_p0;
    end
  end

  assign key_pressed_p1 = key_sync_p1 ^ RAW_RELEASED;

  // ---- debounce: level flips after DEBOUNCE_CYCLES consecutive disagreements
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < N_KEYS; i++) db_cnt[i] <= '0;
      key_level <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (key_pressed_p1[i] == key_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          key_level[i] <= ~key_level[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---- press edge detect: pulse the cycle after the debounced level rises
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      key_level_d <= '0;
      key_press   <= '0;
    end else begin
      key_level_d <= key_level;
      key_press   <= key_level & ~key_level_d;
    end
  end

  // ---- turn filter: compare against the newest pending direction
  assign tail_idx = (wr_ptr == '0) ? PTR_LAST : (wr_ptr - PTR_W'(1));

  always_comb begin
    cand    = pick_turn(key_press[3:0]);
    ref_dir = (q_count != '0) ? fifo_mem[tail_idx] : dir;
    q_full  = (q_count == QC_FULL);
    do_pop  = step && (q_count != '0);
    turn_ok = cand[2] && (cand[1:0] != ref_dir) && (cand[1:0] != (ref_dir ^ 2'b10));
    // A pop in the same cycle frees the slot the push needs.
    do_push = turn_ok && (!q_full || do_pop);
    do_drop = turn_ok && q_full && !do_pop;
  end

  // ---- turn FIFO and direction register
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < QDEPTH; i++) fifo_mem[i] <= 2'd0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      q_count      <= '0;
      dir          <= 2'd0;
      dir_changed  <= 1'b0;
      turn_dropped <= 1'b0;
    end else begin
      dir_changed  <= do_pop;
      turn_dropped <= do_drop;
      if (do_pop) begin
        dir    <= fifo_mem[rd_ptr];
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (do_push) begin
        fifo_mem[wr_ptr] <= cand[1:0];
        wr_ptr           <= ptr_next(wr_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   q_count <= q_count + QC_W'(1);
        2'b01:   q_count <= q_count - QC_W'(1);
        default: q_count <= q_count;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_key_dir_ctrl.sv
// Testbench for snake_key_dir_ctrl with a short debounce, active-high keys
// and a two-entry turn queue.
module tb_snake_key_dir_ctrl;

  localparam int NK  = 4;
  localparam int DB  = 4;
  localparam int QD  = 2;
  localparam bit KAL = 1'b0;
  localparam int QCW = $clog2(QD + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NK-1:0]   key;
  logic            step;
  logic [NK-1:0]   key_level;
  logic [NK-1:0]   key_press;
  logic [1:0]      dir;
  logic            dir_changed;
  logic [QCW-1:0]  q_count;
  logic            turn_dropped;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snake_key_dir_ctrl #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .KEY_ACTIVE_LOW(KAL), .QDEPTH(QD)
  ) dut (
    .CLOCK_50(clk), .Resetn(rst_n), .KEY(key), .step(step),
    .key_level(key_level), .key_press(key_press), .dir(dir),
    .dir_changed(dir_changed), .q_count(q_count), .turn_dropped(turn_dropped)
  );

  // Reference model: raw-sample history, window-based debounce, queue of turns.
  logic [NK-1:0] raw_q[$];
  logic [NK-1:0] m_lvl, m_lvl_old, m_press;
  logic [1:0]    m_dir;
  logic          m_changed, m_drop;
  logic [1:0]    dq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    raw_q.delete();
    for (int i = 0; i < DB + 2; i++) raw_q.push_back({NK{KAL}});
    m_lvl = '0; m_lvl_old = '0; m_press = '0;
    m_dir = 2'd0; m_changed = 1'b0; m_drop = 1'b0;
    dq.delete();
  endtask

  task automatic model_update(input logic step_in, input logic [NK-1:0] key_in);
    logic [NK-1:0] new_lvl, smp;
    logic [1:0]    cand, refd;
    bit            cand_vld, all_diff, pop, full;
    raw_q.push_back(key_in);
    if (raw_q.size() > DB + 3) void'(raw_q.pop_front());
    // The debouncer sees the raw value from two edges ago; a level flips once
    // the last DB seen values all disagree with it.
    new_lvl = m_lvl;
    for (int k = 0; k < NK; k++) begin
      all_diff = 1;
      for (int j = 0; j < DB; j++) begin
        smp = raw_q[raw_q.size() - 3 - j] ^ {NK{KAL}};
        if (smp[k] == m_lvl[k]) all_diff = 0;
      end
      if (all_diff) new_lvl[k] = ~m_lvl[k];
    end
    cand_vld = 0; cand = 2'd0;
    for (int i = 3; i >= 0; i--) if (m_press[i]) begin cand_vld = 1; cand = 2'(i); end
    refd = (dq.size() > 0) ? dq[$] : m_dir;
    full = (dq.size() == QD);
    pop  = step_in && (dq.size() > 0);
    m_changed = pop;
    m_drop    = 1'b0;
    if (pop) m_dir = dq.pop_front();
    if (cand_vld && cand != refd && cand != (refd ^ 2'b10)) begin
      if (!full || pop) dq.push_back(cand);
      else m_drop = 1'b1;
    end
    m_press   = m_lvl & ~m_lvl_old;
    m_lvl_old = m_lvl;
    m_lvl     = new_lvl;
  endtask

  task automatic check_model();
    logic [13:0] act, exp;
    act = {key_level, key_press, dir, dir_changed, q_count, turn_dropped};
    exp = {m_lvl, m_press, m_dir, m_changed, QCW'(dq.size()), m_drop};
    check("model", 32'(act), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update(step, key);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset outputs", 32'({key_level, key_press, dir, dir_changed, q_count, turn_dropped}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic do_press(input int idx, output int np, output int nc, output int nd);
    np = 0; nc = 0; nd = 0;
    key[idx] = 1'b1;
    repeat (10) begin tick(); np += key_press[idx]; nc += dir_changed; nd += turn_dropped; end
    key[idx] = 1'b0;
    repeat (10) begin tick(); np += key_press[idx]; nc += dir_changed; nd += turn_dropped; end
  endtask

  task automatic do_step(output int nc, output int nd);
    nc = 0; nd = 0;
    step = 1'b1;
    tick(); nc += dir_changed; nd += turn_dropped;
    step = 1'b0;
    repeat (3) begin tick(); nc += dir_changed; nd += turn_dropped; end
  endtask

  typedef struct {
    int op;        // 0 press key idx, 1 step
    int idx;
    int exp_dir;
    int exp_qc;
    int exp_presses;
    int exp_changes;
    int exp_drops;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int np, nc, nd, first_lvl, first_press, qc8, lvl_seen, press_seen;
    int hold[NK];

    vecs[0]  = '{0, 2, 0, 0, 1, 0, 0};  // LEFT vs RIGHT: reversal
    vecs[1]  = '{0, 0, 0, 0, 1, 0, 0};  // RIGHT vs RIGHT: no-op
    vecs[2]  = '{0, 1, 0, 1, 1, 0, 0};  // UP queued
    vecs[3]  = '{1, 0, 1, 0, 0, 1, 0};
    vecs[4]  = '{0, 0, 1, 1, 1, 0, 0};  // RIGHT vs UP queued
    vecs[5]  = '{1, 0, 0, 0, 0, 1, 0};
    vecs[6]  = '{0, 1, 0, 1, 1, 0, 0};  // UP
    vecs[7]  = '{0, 2, 0, 2, 1, 0, 0};  // LEFT vs tail UP
    vecs[8]  = '{0, 3, 0, 2, 1, 0, 1};  // DOWN vs tail LEFT, queue full
    vecs[9]  = '{1, 0, 1, 1, 0, 1, 0};
    vecs[10] = '{1, 0, 2, 0, 0, 1, 0};
    vecs[11] = '{1, 0, 2, 0, 0, 0, 0};  // empty queue: nothing
    vecs[12] = '{0, 0, 2, 0, 1, 0, 0};  // RIGHT vs LEFT: reversal
    vecs[13] = '{0, 3, 2, 1, 1, 0, 0};  // DOWN queued

    key = '0; step = 1'b0; rst_n = 1'b0;
    model_reset();
    #2;
    check("reset outputs", 32'({key_level, key_press, dir, dir_changed, q_count, turn_dropped}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Press latency and single pulse, then one step.
    key[1] = 1'b1;
    first_lvl = 0; first_press = 0; np = 0; qc8 = -1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (key_level[1] && first_lvl == 0) first_lvl = t;
      if (key_press[1]) begin np++; if (first_press == 0) first_press = t; end
      if (t == 8) qc8 = int'(q_count);
    end
    check("level latency", 32'(first_lvl), 32'd6);
    check("press latency", 32'(first_press), 32'd7);
    check("press pulses", 32'(np), 32'd1);
    check("q after press", 32'(qc8), 32'd1);
    key[1] = 1'b0;
    repeat (8) tick();
    step = 1'b1;
    tick();
    check("step dir", 32'(dir), 32'd1);
    check("step changed", 32'(dir_changed), 32'd1);
    step = 1'b0;
    tick();
    check("changed once", 32'(dir_changed), 32'd0);
    check("q after step", 32'(q_count), 32'd0);

    // Three-cycle glitch on key 2.
    lvl_seen = 0; press_seen = 0;
    key[2] = 1'b1;
    repeat (3) begin tick(); lvl_seen += key_level[2]; press_seen += key_press[2]; end
    key[2] = 1'b0;
    repeat (10) begin tick(); lvl_seen += key_level[2]; press_seen += key_press[2]; end
    check("glitch level", 32'(lvl_seen), 32'd0);
    check("glitch press", 32'(press_seen), 32'd0);
    check("glitch q", 32'(q_count), 32'd0);

    // Table of press/step events from a fresh reset.
    do_reset();
    tick();
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].op == 0) do_press(vecs[v].idx, np, nc, nd);
      else begin np = 0; do_step(nc, nd); end
      check($sformatf("vec%0d dir", v), 32'(dir), 32'(vecs[v].exp_dir));
      check($sformatf("vec%0d q_count", v), 32'(q_count), 32'(vecs[v].exp_qc));
      check($sformatf("vec%0d presses", v), 32'(np), 32'(vecs[v].exp_presses));
      check($sformatf("vec%0d changes", v), 32'(nc), 32'(vecs[v].exp_changes));
      check($sformatf("vec%0d drops", v), 32'(nd), 32'(vecs[v].exp_drops));
    end

    // Full queue, step in the same cycle as a DOWN press.
    do_reset();
    tick();
    do_press(1, np, nc, nd);
    do_press(2, np, nc, nd);
    check("full q", 32'(q_count), 32'd2);
    key[3] = 1'b1;
    repeat (7) tick();
    check("down press ready", 32'(key_press[3]), 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("push+pop q", 32'(q_count), 32'd2);
    check("push+pop no drop", 32'(turn_dropped), 32'd0);
    check("push+pop dir", 32'(dir), 32'd1);
    check("push+pop changed", 32'(dir_changed), 32'd1);
    key[3] = 1'b0;
    repeat (10) tick();
    do_step(nc, nd);
    check("drain dir 1", 32'(dir), 32'd2);
    do_step(nc, nd);
    check("drain dir 2", 32'(dir), 32'd3);

    // Simultaneous RIGHT and DOWN at dir UP, then reset mid-queue.
    do_press(0, np, nc, nd);
    do_step(nc, nd);
    do_press(1, np, nc, nd);
    do_step(nc, nd);
    check("dir up", 32'(dir), 32'd1);
    key = 4'b1001;
    repeat (10) tick();
    check("only right queued", 32'(q_count), 32'd1);
    key = '0;
    repeat (3) tick();
    do_reset();

    // Randomised run against the model.
    for (int k = 0; k < NK; k++) hold[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          key[k]  = 1'($urandom_range(0, 1));
          hold[k] = $urandom_range(1, 14);
        end else hold[k]--;
      end
      step = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 699) == 0) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
